steer_en_ctrl: RTL
==================

STEER_EN_CTRL -- requirements
Module: steer_en_ctrl

Interface
REQ-001 Parameter LD_W, default 12, width of each load-cell input.
REQ-002 Parameter MIN_WT, default 12'h200, rider-on threshold on the load sum.
REQ-003 Parameter HYST, default 12'h020, hysteresis; rider-off threshold is MIN_WT-HYST; HYST < MIN_WT SHALL hold.
REQ-004 Parameter SETTLE_CYC, default 65_000_000, balanced-standing cycles required before steering (1.3 s at 50 MHz).
REQ-005 Parameter GRACE_CYC, default 5_000_000, cycles a step-off imbalance must persist before steering is dropped.
REQ-006 clk  input  1  system clock; all logic on the rising edge.
REQ-007 rst  input  1  reset, synchronous, active-high.
REQ-008 lft_ld  input  LD_W  left load cell, unsigned.
REQ-009 rght_ld  input  LD_W  right load cell, unsigned.
REQ-010 en_steer  output  1  steering enable to balance control.
REQ-011 rider_off  output  1  one-cycle pulse when rider leaves the platform.
REQ-012 state_o  output  2  current state encoding: IDLE=0, WAIT=1, STEER_EN=2, STEP_OFF=3.

Function
REQ-013 Arithmetic: sum = lft_ld+rght_ld, LD_W+1 bits; diff = |lft_ld-rght_ld|, LD_W bits; no overflow or wrap.
REQ-014 Flags: on = sum > MIN_WT; off = sum < MIN_WT-HYST; imb = diff > (sum>>2); stepoff = diff > sum-(sum>>4); all strict compares, unsigned.
REQ-015 Internal settle counter and grace counter, each sized ceil(log2) of its parameter; neither wraps.
REQ-016 IDLE: on -> WAIT with settle counter cleared; otherwise stay.
REQ-017 WAIT priority: off -> IDLE; else imb -> stay, settle counter cleared; else counter == SETTLE_CYC-1 -> STEER_EN; else stay, counter +1.
REQ-018 STEER_EN priority: off -> IDLE; else stepoff -> STEP_OFF with grace counter cleared; else stay.
REQ-019 STEP_OFF priority: off -> IDLE; else !stepoff -> STEER_EN; else grace counter == GRACE_CYC-1 -> WAIT with settle counter cleared; else stay, grace counter +1.
REQ-020 en_steer is 1 exactly when the state is STEER_EN or STEP_OFF (Moore output, registered state, no glitch).
REQ-021 rider_off is registered and high for exactly one cycle, the cycle after any WAIT/STEER_EN/STEP_OFF -> IDLE transition; it is never high in consecutive cycles.
REQ-022 Latency: with balanced load held from the first WAIT cycle, en_steer rises exactly SETTLE_CYC cycles after entry to WAIT.
REQ-023 Hysteresis: sum in [MIN_WT-HYST, MIN_WT] holds the current state (no entry from IDLE, no exit to IDLE).
REQ-024 Simultaneous off and imb/stepoff/timer conditions: off wins.
REQ-025 An unused state encoding (none with 2 bits, but for safety) returns to IDLE with counters cleared.

Reset
REQ-026 While rst is high at a clock edge: state = IDLE, both counters = 0, rider_off = 0, en_steer = 0, state_o = 0.
REQ-027 Reset asserted in any state (including mid-count and STEER_EN) SHALL NOT produce a rider_off pulse.
REQ-028 The first edge with rst low evaluates IDLE transitions normally.

Verification (bench uses SETTLE_CYC=16, GRACE_CYC=4, defaults otherwise)
REQ-029 lft=rght=0x180 from IDLE -> WAIT next cycle; en_steer rises 16 cycles later; state_o=2.
REQ-030 In WAIT at count 10, lft=0x300, rght=0x080 (imb) for 1 cycle, then balanced -> counter restarts; en_steer rises 16 cycles after balance restored.
REQ-031 In STEER_EN, lft=0x3F0, rght=0x008 for 3 cycles then balanced -> STEP_OFF then STEER_EN; en_steer stays 1 throughout; held 4+ cycles -> WAIT, en_steer drops.
REQ-032 In STEER_EN, sum stepped to 0x1F0 -> stays STEER_EN (hysteresis); sum 0x1D0 -> IDLE next cycle, rider_off high exactly one cycle, en_steer 0.
REQ-033 rst pulsed one cycle in STEER_EN -> IDLE, en_steer 0, rider_off never asserted; rider remaining on -> WAIT on the following cycle.
REQ-034 Idle with sum exactly 0x200 -> stays IDLE; 0x201 -> WAIT.

Source files
------------

// File: rtl/steer_en_ctrl_if.sv
// rtl/steer_en_ctrl_if.sv - load-cell inputs and steering-enable outputs of steer_en_ctrl
interface steer_en_ctrl_if #(
    parameter int LD_W = 12
);
    logic [LD_W-1:0] lft_ld;
    logic [LD_W-1:0] rght_ld;
    logic            en_steer;
    logic            rider_off;
    logic [1:0]      state_o;

    modport master (
        output lft_ld,
        output rght_ld,
        input  en_steer,
        input  rider_off,
        input  state_o
    );

    modport slave (
        input  lft_ld,
        input  rght_ld,
        output en_steer,
        output rider_off,
        output state_o
    );
endinterface

// File: rtl/steer_en_ctrl.sv
// rtl/steer_en_ctrl.sv - rider-presence FSM gating steering on balanced, settled load
module steer_en_ctrl #(
    parameter int LD_W       = 12,
    parameter int MIN_WT     = 'h200,
    parameter int HYST       = 'h020,
    parameter int SETTLE_CYC = 65_000_000,
    parameter int GRACE_CYC  = 5_000_000
) (
    input  logic            clk,
    input  logic            rst,
    steer_en_ctrl_if.slave  bus
);
    localparam int SW = (SETTLE_CYC > 1) ? $clog2(SETTLE_CYC) : 1;
    localparam int GW = (GRACE_CYC > 1) ? $clog2(GRACE_CYC) : 1;
    localparam logic [SW-1:0] SETTLE_LAST = SW'(SETTLE_CYC - 1);
    localparam logic [GW-1:0] GRACE_LAST  = GW'(GRACE_CYC - 1);
    localparam logic [LD_W:0] ON_TH       = (LD_W + 1)'(MIN_WT);
    localparam logic [LD_W:0] OFF_TH      = (LD_W + 1)'(MIN_WT - HYST);

    typedef enum logic [1:0] {
        S_IDLE     = 2'd0,
        S_WAIT     = 2'd1,
        S_STEER_EN = 2'd2,
        S_STEP_OFF = 2'd3
    } state_t;

    state_t          r_state;
    state_t          w_next;
    logic [SW-1:0]   r_settle;
    logic [SW-1:0]   w_settle_nxt;
    logic [GW-1:0]   r_grace;
    logic [GW-1:0]   w_grace_nxt;
    logic            r_rider_off;
    logic            w_rider_off_nxt;

    logic [LD_W:0]   w_sum;
    logic [LD_W-1:0] w_diff;
    logic            w_on;
    logic            w_off;
    logic            w_imb;
    logic            w_stepoff;

    // Sum carries one extra bit; sum>>4 never exceeds sum, so the step-off bound cannot wrap.
    assign w_sum     = {1'b0, bus.lft_ld} + {1'b0, bus.rght_ld};
    assign w_diff    = (bus.lft_ld >= bus.rght_ld) ? (bus.lft_ld - bus.rght_ld)
                                                   : (bus.rght_ld - bus.lft_ld);
    assign w_on      = w_sum > ON_TH;
    assign w_off     = w_sum < OFF_TH;
    assign w_imb     = {1'b0, w_diff} > (w_sum >> 2);
    assign w_stepoff = {1'b0, w_diff} > (w_sum - (w_sum >> 4));

    always_comb begin
        w_next       = r_state;
        w_settle_nxt = r_settle;
        w_grace_nxt  = r_grace;
        case (r_state)
            S_IDLE: begin
                if (w_on) begin
                    w_next       = S_WAIT;
                    w_settle_nxt = '0;
                end
            end
            S_WAIT: begin
                if (w_off) begin
                    w_next = S_IDLE;
                end else if (w_imb) begin
                    w_settle_nxt = '0;
                end else if (r_settle == SETTLE_LAST) begin
                    w_next = S_STEER_EN;
                end else begin
                    w_settle_nxt = r_settle + 1'b1;
                end
            end
            S_STEER_EN: begin
                if (w_off) begin
                    w_next = S_IDLE;
                end else if (w_stepoff) begin
                    w_next      = S_STEP_OFF;
                    w_grace_nxt = '0;
                end
            end
            S_STEP_OFF: begin
                if (w_off) begin
                    w_next = S_IDLE;
                end else if (!w_stepoff) begin
                    w_next = S_STEER_EN;
                end else if (r_grace == GRACE_LAST) begin
                    w_next       = S_WAIT;
                    w_settle_nxt = '0;
                end else begin
                    w_grace_nxt = r_grace + 1'b1;
                end
            end
            default: begin
                w_next       = S_IDLE;
                w_settle_nxt = '0;
                w_grace_nxt  = '0;
            end
        endcase
    end

    // Only FSM-driven exits pulse rider_off; reset bypasses this path entirely.
    assign w_rider_off_nxt = (r_state != S_IDLE) && (w_next == S_IDLE);

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state     <= S_IDLE;
            r_settle    <= '0;
            r_grace     <= '0;
            r_rider_off <= 1'b0;
        end else begin
            r_state     <= w_next;
            r_settle    <= w_settle_nxt;
            r_grace     <= w_grace_nxt;
            r_rider_off <= w_rider_off_nxt;
        end
    end

    assign bus.en_steer  = (r_state == S_STEER_EN) || (r_state == S_STEP_OFF);
    assign bus.rider_off = r_rider_off;
    assign bus.state_o   = r_state;
endmodule
